id_stage_pipelined: RTL and testbench
=====================================

ID_STAGE_PIPELINED -- requirements
Module: id_stage_pipelined

Interface
REQ-001 Parameter WORD_WIDTH, 32, datapath width.
REQ-002 Parameter REG_ADDR_W, 4, register address width; register count = 2**REG_ADDR_W.
REQ-003 Parameter BYPASS_EN, 1, enables same-cycle write-back forwarding into operand read.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid / in_ready  input / output  1 / 1  IF->ID handshake.
REQ-007 pc_in, instr_in  input  WORD_WIDTH each  fetched PC and instruction.
REQ-008 wb_en, wb_addr, wb_data  input  1, REG_ADDR_W, WORD_WIDTH  register-file write port.
REQ-009 status  input  4  NZCV flags for condition evaluation.
REQ-010 flush  input  1  branch-taken kill from EX.
REQ-011 out_valid / out_ready  output / input  1 / 1  ID->EX handshake.
REQ-012 out_pc, out_instr, out_rn, out_rm  output  WORD_WIDTH each  registered PC, instruction, operand values.
REQ-013 out_dst  output  REG_ADDR_W  instr[15:12].
REQ-014 out_imm24, out_shift  output  24, 12  instr[23:0], instr[11:0].
REQ-015 out_exe_cmd, out_mem_read, out_mem_write, out_wb_en, out_imm, out_b, out_s  output  4,1,1,1,1,1,1  registered control.

Function
REQ-016 Decode is combinational on instr_in; all out_* SHALL be registered (ID/EX register), latency exactly 1 cycle from accepted input.
REQ-017 Input accepted when in_valid && in_ready; ID/EX register loads when empty or out_ready=1.
REQ-018 in_ready = (~out_valid | out_ready) & ~hazard.
REQ-019 src1 = instr[19:16]; src2 = instr[15:12] when decoded mem_write, else instr[3:0].
REQ-020 Register file: 2**REG_ADDR_W x WORD_WIDTH, write on clk when wb_en; with BYPASS_EN=1, a read whose address equals wb_addr while wb_en=1 SHALL return wb_data same cycle; with BYPASS_EN=0, returns old value.
REQ-021 Condition evaluation per ARM cond field (EQ..AL, 0xF treated as never); failing condition SHALL zero all control outputs (exe_cmd, mem_read, mem_write, wb_en, b, s) but still pass the instruction with out_valid=1.
REQ-022 Load-use hazard: hazard=1 when out_valid & out_mem_read & out_wb_en & in_valid and out_dst equals src1, or equals src2 where src2 is used (not immediate, or mem_write); while hazard, stage holds input and, when out_ready=1, loads a bubble (out_valid=0).
REQ-023 Hazard lasts exactly one cycle per dependent load if out_ready stays 1.
REQ-024 flush=1: ID/EX register SHALL load out_valid=0 next edge, input in that cycle is consumed and discarded (in_ready forced 1); flush overrides hazard and out_ready.
REQ-025 out_ready=0 and no flush: ID/EX register holds all values unchanged.
REQ-026 Simultaneous wb_en write and decode of same register follow REQ-020; write to register during stall is visible on retry.

Reset
REQ-027 On rst: out_valid=0, all out_* data and control = 0, register file all zero, in_ready=1 the cycle after rst deasserts.
REQ-028 rst mid-stall or mid-backpressure SHALL discard held instruction; no output beat emitted.

Structure
REQ-029 Condition codes, exe_cmd encodings, mode/opcode constants and control-bundle struct go in shared package sloth_pkg.
REQ-030 Control decode as sub-module control_decoder; register file as sub-module reg_file_bypass; remaining logic inline.

Verification
REQ-031 Reset, then ADD r1,r2,r3 (cond AL) with r2=5,r3=7 preset -> next cycle out_valid=1, out_rn=5, out_rm=7, out_wb_en=1, out_dst=1.
REQ-032 LDR r4,[r5] followed by ADD r6,r4,r7 -> one bubble (out_valid=0 one cycle), in_ready=0 one cycle, ADD emitted next.
REQ-033 ADDEQ with status Z=0 -> out_valid=1, all control outputs 0.
REQ-034 wb_en=1, wb_addr=2, wb_data=0xDEAD_BEEF same cycle as decode reading r2 -> out_rn=0xDEADBEEF (BYPASS_EN=1); old value (BYPASS_EN=0).
REQ-035 out_ready=0 for 3 cycles with valid output -> outputs stable, in_ready=0; then flush=1 -> out_valid=0 next cycle.
REQ-036 rst asserted during hazard stall -> all outputs 0, no stale beat after release.

Source files
------------

// File: rtl/sloth_pkg.sv
// rtl/sloth_pkg.sv - shared condition codes, opcodes, exe commands and control bundle
// Instruction layout: cond[31:28] mode[27:26] imm[25] opcode[24:21] s[20] rn[19:16] rd[15:12] shift[11:0].
package sloth_pkg;

   typedef enum logic [3:0] {
      COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
      COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
      COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
      COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
   } cond_e;

   localparam logic [1:0] MODE_ARITH  = 2'b00;
   localparam logic [1:0] MODE_MEM    = 2'b01;
   localparam logic [1:0] MODE_BRANCH = 2'b10;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_EOR = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_ADC = 4'b0101;
   localparam logic [3:0] OP_SBC = 4'b0110;
   localparam logic [3:0] OP_TST = 4'b1000;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_MOV = 4'b1101;
   localparam logic [3:0] OP_MVN = 4'b1111;

   localparam logic [3:0] EXE_NOP = 4'h0;
   localparam logic [3:0] EXE_MOV = 4'h1;
   localparam logic [3:0] EXE_ADD = 4'h2;
   localparam logic [3:0] EXE_ADC = 4'h3;
   localparam logic [3:0] EXE_SUB = 4'h4;
   localparam logic [3:0] EXE_SBC = 4'h5;
   localparam logic [3:0] EXE_AND = 4'h6;
   localparam logic [3:0] EXE_ORR = 4'h7;
   localparam logic [3:0] EXE_EOR = 4'h8;
   localparam logic [3:0] EXE_MVN = 4'h9;

   typedef struct packed {
      logic [3:0] exe_cmd;
      logic       mem_read;
      logic       mem_write;
      logic       wb_en;
      logic       imm;
      logic       b;
      logic       s;
   } ctrl_t;

   // nzcv is packed {N, Z, C, V}; 0xF never executes.
   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n, z, c, v, pass;
      {n, z, c, v} = nzcv;
      case (cond_e'(cond))
         COND_EQ: pass = z;
         COND_NE: pass = ~z;
         COND_CS: pass = c;
         COND_CC: pass = ~c;
         COND_MI: pass = n;
         COND_PL: pass = ~n;
         COND_VS: pass = v;
         COND_VC: pass = ~v;
         COND_HI: pass = c & ~z;
         COND_LS: pass = ~c | z;
         COND_GE: pass = (n == v);
         COND_LT: pass = (n != v);
         COND_GT: pass = ~z & (n == v);
         COND_LE: pass = z | (n != v);
         COND_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
      return pass;
   endfunction

endpackage

// File: rtl/control_decoder.sv
// rtl/control_decoder.sv - combinational control decode with condition gating
// raw_mem_write_o is the ungated store flag, used to pick which register the instruction reads.
module control_decoder
   import sloth_pkg::*;
(
   input  logic [31:0] instr_i,
   input  logic [3:0]  status_i,
   output logic [3:0]  exe_cmd_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   output logic        wb_en_o,
   output logic        imm_o,
   output logic        b_o,
   output logic        s_o,
   output logic        raw_mem_write_o
);

   ctrl_t raw;
   logic  pass;

   always_comb begin
      raw     = '0;
      raw.imm = instr_i[25];
      case (instr_i[27:26])
         MODE_ARITH: begin
            raw.s     = instr_i[20];
            raw.wb_en = 1'b1;
            case (instr_i[24:21])
               OP_MOV:  raw.exe_cmd = EXE_MOV;
               OP_MVN:  raw.exe_cmd = EXE_MVN;
               OP_ADD:  raw.exe_cmd = EXE_ADD;
               OP_ADC:  raw.exe_cmd = EXE_ADC;
               OP_SUB:  raw.exe_cmd = EXE_SUB;
               OP_SBC:  raw.exe_cmd = EXE_SBC;
               OP_AND:  raw.exe_cmd = EXE_AND;
               OP_ORR:  raw.exe_cmd = EXE_ORR;
               OP_EOR:  raw.exe_cmd = EXE_EOR;
               OP_CMP: begin
                  raw.exe_cmd = EXE_SUB;
                  raw.wb_en   = 1'b0;
               end
               OP_TST: begin
                  raw.exe_cmd = EXE_AND;
                  raw.wb_en   = 1'b0;
               end
               default: raw.wb_en = 1'b0;
            endcase
         end
         // S bit distinguishes LDR (1) from STR (0); both compute base + offset.
         MODE_MEM: begin
            raw.exe_cmd   = EXE_ADD;
            raw.mem_read  = instr_i[20];
            raw.wb_en     = instr_i[20];
            raw.mem_write = ~instr_i[20];
         end
         MODE_BRANCH: raw.b = 1'b1;
         default: ;
      endcase
   end

   assign pass = cond_pass(instr_i[31:28], status_i);

   assign exe_cmd_o       = pass ? raw.exe_cmd : EXE_NOP;
   assign mem_read_o      = pass & raw.mem_read;
   assign mem_write_o     = pass & raw.mem_write;
   assign wb_en_o         = pass & raw.wb_en;
   assign b_o             = pass & raw.b;
   assign s_o             = pass & raw.s;
   assign imm_o           = raw.imm;
   assign raw_mem_write_o = raw.mem_write;

endmodule

// File: rtl/reg_file_bypass.sv
// rtl/reg_file_bypass.sv - two-read one-write register file with optional write-through
module reg_file_bypass #(
   parameter int WORD_WIDTH = 32,
   parameter int REG_ADDR_W = 4,
   parameter int BYPASS_EN  = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  we_i,
   input  logic [REG_ADDR_W-1:0] waddr_i,
   input  logic [WORD_WIDTH-1:0] wdata_i,
   input  logic [REG_ADDR_W-1:0] raddr1_i,
   output logic [WORD_WIDTH-1:0] rdata1_o,
   input  logic [REG_ADDR_W-1:0] raddr2_i,
   output logic [WORD_WIDTH-1:0] rdata2_o
);

   localparam int NREGS = 1 << REG_ADDR_W;

   logic [WORD_WIDTH-1:0] regs_q [NREGS];
   logic                  fwd1, fwd2;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign fwd1 = (BYPASS_EN != 0) && we_i && (waddr_i == raddr1_i);
   assign fwd2 = (BYPASS_EN != 0) && we_i && (waddr_i == raddr2_i);

   assign rdata1_o = fwd1 ? wdata_i : regs_q[raddr1_i];
   assign rdata2_o = fwd2 ? wdata_i : regs_q[raddr2_i];

endmodule

// File: rtl/id_stage_pipelined.sv
// rtl/id_stage_pipelined.sv - decode stage with ID/EX register, load-use stall and flush
// Bubbles and flushes load an all-zero ID/EX register, so a dead slot never carries stale control.
module id_stage_pipelined
   import sloth_pkg::*;
#(
   parameter int WORD_WIDTH = 32,
   parameter int REG_ADDR_W = 4,
   parameter int BYPASS_EN  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORD_WIDTH-1:0] pc_in,
   input  logic [WORD_WIDTH-1:0] instr_in,
   input  logic                  wb_en,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [WORD_WIDTH-1:0] wb_data,
   input  logic [3:0]            status,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WORD_WIDTH-1:0] out_pc,
   output logic [WORD_WIDTH-1:0] out_instr,
   output logic [WORD_WIDTH-1:0] out_rn,
   output logic [WORD_WIDTH-1:0] out_rm,
   output logic [REG_ADDR_W-1:0] out_dst,
   output logic [23:0]           out_imm24,
   output logic [11:0]           out_shift,
   output logic [3:0]            out_exe_cmd,
   output logic                  out_mem_read,
   output logic                  out_mem_write,
   output logic                  out_wb_en,
   output logic                  out_imm,
   output logic                  out_b,
   output logic                  out_s
);

   typedef struct packed {
      logic                  valid;
      logic [WORD_WIDTH-1:0] pc;
      logic [WORD_WIDTH-1:0] instr;
      logic [WORD_WIDTH-1:0] rn;
      logic [WORD_WIDTH-1:0] rm;
      logic [REG_ADDR_W-1:0] dst;
      ctrl_t                 ctrl;
   } idex_t;

   idex_t                 idex_d, idex_q;
   ctrl_t                 dec_ctrl;
   logic                  dec_raw_mem_write;
   logic [REG_ADDR_W-1:0] src1, src2, dst;
   logic                  src2_used, hazard;
   logic [WORD_WIDTH-1:0] rn_val, rm_val;

   control_decoder u_ctrl (
      .instr_i         (instr_in[31:0]),
      .status_i        (status),
      .exe_cmd_o       (dec_ctrl.exe_cmd),
      .mem_read_o      (dec_ctrl.mem_read),
      .mem_write_o     (dec_ctrl.mem_write),
      .wb_en_o         (dec_ctrl.wb_en),
      .imm_o           (dec_ctrl.imm),
      .b_o             (dec_ctrl.b),
      .s_o             (dec_ctrl.s),
      .raw_mem_write_o (dec_raw_mem_write)
   );

   // Stores read their data register from the rd field instead of rm.
   assign src1      = REG_ADDR_W'(instr_in[19:16]);
   assign src2      = dec_raw_mem_write ? REG_ADDR_W'(instr_in[15:12]) : REG_ADDR_W'(instr_in[3:0]);
   assign dst       = REG_ADDR_W'(instr_in[15:12]);
   assign src2_used = ~dec_ctrl.imm | dec_raw_mem_write;

   reg_file_bypass #(
      .WORD_WIDTH (WORD_WIDTH),
      .REG_ADDR_W (REG_ADDR_W),
      .BYPASS_EN  (BYPASS_EN)
   ) u_rf (
      .clk_i    (clk),
      .rst_i    (rst),
      .we_i     (wb_en),
      .waddr_i  (wb_addr),
      .wdata_i  (wb_data),
      .raddr1_i (src1),
      .rdata1_o (rn_val),
      .raddr2_i (src2),
      .rdata2_o (rm_val)
   );

   assign hazard = idex_q.valid & idex_q.ctrl.mem_read & idex_q.ctrl.wb_en & in_valid &
                   ((idex_q.dst == src1) | (src2_used & (idex_q.dst == src2)));

   assign in_ready = flush | ((~idex_q.valid | out_ready) & ~hazard);

   always_comb begin
      idex_d = idex_q;
      if (flush) begin
         idex_d = '0;
      end else if (~idex_q.valid | out_ready) begin
         idex_d = '0;
         if (in_valid & ~hazard) begin
            idex_d.valid = 1'b1;
            idex_d.pc    = pc_in;
            idex_d.instr = instr_in;
            idex_d.rn    = rn_val;
            idex_d.rm    = rm_val;
            idex_d.dst   = dst;
            idex_d.ctrl  = dec_ctrl;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) idex_q <= '0;
      else     idex_q <= idex_d;
   end

   assign out_valid     = idex_q.valid;
   assign out_pc        = idex_q.pc;
   assign out_instr     = idex_q.instr;
   assign out_rn        = idex_q.rn;
   assign out_rm        = idex_q.rm;
   assign out_dst       = idex_q.dst;
   assign out_imm24     = idex_q.instr[23:0];
   assign out_shift     = idex_q.instr[11:0];
   assign out_exe_cmd   = idex_q.ctrl.exe_cmd;
   assign out_mem_read  = idex_q.ctrl.mem_read;
   assign out_mem_write = idex_q.ctrl.mem_write;
   assign out_wb_en     = idex_q.ctrl.wb_en;
   assign out_imm       = idex_q.ctrl.imm;
   assign out_b         = idex_q.ctrl.b;
   assign out_s         = idex_q.ctrl.s;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// tb/tb_id_stage_pipelined.sv - directed and random checks of id_stage_pipelined against a beat-level model
module tb_id_stage_pipelined;

   logic        clk = 1'b0;
   logic        rst, in_valid, wb_en, flush, out_ready;
   logic [31:0] pc_in, instr_in, wb_data;
   logic [3:0]  wb_addr, status;

   logic        in_ready, out_valid, out_mem_read, out_mem_write, out_wb_en, out_imm, out_b, out_s;
   logic [31:0] out_pc, out_instr, out_rn, out_rm;
   logic [3:0]  out_dst, out_exe_cmd;
   logic [23:0] out_imm24;
   logic [11:0] out_shift;

   logic        nb_in_ready, nb_out_valid, nb_mem_read, nb_mem_write, nb_wb_en, nb_imm, nb_b, nb_s;
   logic [31:0] nb_out_pc, nb_out_instr, nb_out_rn, nb_out_rm;
   logic [3:0]  nb_out_dst, nb_exe_cmd;
   logic [23:0] nb_imm24;
   logic [11:0] nb_shift;

   always #5 clk = ~clk;

   id_stage_pipelined #(.WORD_WIDTH(32), .REG_ADDR_W(4), .BYPASS_EN(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_in(pc_in),
      .instr_in(instr_in), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .status(status), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_instr(out_instr), .out_rn(out_rn), .out_rm(out_rm),
      .out_dst(out_dst), .out_imm24(out_imm24), .out_shift(out_shift),
      .out_exe_cmd(out_exe_cmd), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_wb_en(out_wb_en), .out_imm(out_imm), .out_b(out_b), .out_s(out_s)
   );

   id_stage_pipelined #(.WORD_WIDTH(32), .REG_ADDR_W(4), .BYPASS_EN(0)) dut_nb (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nb_in_ready), .pc_in(pc_in),
      .instr_in(instr_in), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .status(status), .flush(flush), .out_valid(nb_out_valid), .out_ready(out_ready),
      .out_pc(nb_out_pc), .out_instr(nb_out_instr), .out_rn(nb_out_rn), .out_rm(nb_out_rm),
      .out_dst(nb_out_dst), .out_imm24(nb_imm24), .out_shift(nb_shift),
      .out_exe_cmd(nb_exe_cmd), .out_mem_read(nb_mem_read), .out_mem_write(nb_mem_write),
      .out_wb_en(nb_wb_en), .out_imm(nb_imm), .out_b(nb_b), .out_s(nb_s)
   );

   typedef struct {
      bit          v;
      logic [31:0] pc, instr, rn, rm;
      logic [3:0]  dst, exe;
      bit          mr, mw, wb, imm, b, s;
   } beat_t;

   beat_t       slot;
   logic [31:0] regs [16];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [3:0] cond, input logic [1:0] mode, input logic imm,
                                      input logic [3:0] op, input logic s, input logic [3:0] rn,
                                      input logic [3:0] rd, input logic [11:0] sh);
      return {cond, mode, imm, op, s, rn, rd, sh};
   endfunction

   function automatic bit cond_ok(input logic [3:0] cond, input logic [3:0] f);
      bit n = f[3], z = f[2], c = f[1], v = f[0];
      case (cond)
         4'h0: return z;          4'h1: return !z;
         4'h2: return c;          4'h3: return !c;
         4'h4: return n;          4'h5: return !n;
         4'h6: return v;          4'h7: return !v;
         4'h8: return c && !z;    4'h9: return !c || z;
         4'hA: return n == v;     4'hB: return n != v;
         4'hC: return !z && n == v;
         4'hD: return z || n != v;
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Arithmetic opcode -> {exe_cmd, writes_back}.
   function automatic logic [4:0] arith(input logic [3:0] op);
      case (op)
         4'hD: return {4'd1, 1'b1};  4'hF: return {4'd9, 1'b1};
         4'h4: return {4'd2, 1'b1};  4'h5: return {4'd3, 1'b1};
         4'h2: return {4'd4, 1'b1};  4'h6: return {4'd5, 1'b1};
         4'h0: return {4'd6, 1'b1};  4'hC: return {4'd7, 1'b1};
         4'h1: return {4'd8, 1'b1};  4'hA: return {4'd4, 1'b0};
         4'h8: return {4'd6, 1'b0};
         default: return 5'd0;
      endcase
   endfunction

   function automatic logic [31:0] rdreg(input logic [3:0] a);
      return (wb_en && wb_addr == a) ? wb_data : regs[a];
   endfunction

   function automatic bit is_store();
      return instr_in[27:26] == 2'b01 && !instr_in[20];
   endfunction

   function automatic logic [3:0] src2_of();
      return is_store() ? instr_in[15:12] : instr_in[3:0];
   endfunction

   function automatic bit model_hazard();
      bit uses2 = !instr_in[25] || is_store();
      return slot.v && slot.mr && slot.wb && in_valid &&
             (slot.dst == instr_in[19:16] || (uses2 && slot.dst == src2_of()));
   endfunction

   function automatic bit model_ready();
      return flush || ((!slot.v || out_ready) && !model_hazard());
   endfunction

   function automatic beat_t decode_beat();
      beat_t       e = '{default: 0};
      logic [4:0]  a;
      e.v = 1; e.pc = pc_in; e.instr = instr_in; e.dst = instr_in[15:12]; e.imm = instr_in[25];
      case (instr_in[27:26])
         2'b00: begin a = arith(instr_in[24:21]); e.exe = a[4:1]; e.wb = a[0]; e.s = instr_in[20]; end
         2'b01: begin e.exe = 4'd2; e.mr = instr_in[20]; e.wb = instr_in[20]; e.mw = !instr_in[20]; end
         2'b10: e.b = 1;
         default: ;
      endcase
      if (!cond_ok(instr_in[31:28], status)) begin
         e.exe = 0; e.mr = 0; e.mw = 0; e.wb = 0; e.b = 0; e.s = 0;
      end
      e.rn = rdreg(instr_in[19:16]);
      e.rm = rdreg(src2_of());
      return e;
   endfunction

   task automatic model_reset();
      slot = '{default: 0};
      for (int i = 0; i < 16; i++) regs[i] = 32'd0;
   endtask

   task automatic model_advance();
      beat_t nxt;
      if (rst) begin
         model_reset();
         return;
      end
      nxt = slot;
      if (flush) nxt = '{default: 0};
      else if (!slot.v || out_ready) nxt = (in_valid && !model_hazard()) ? decode_beat() : '{default: 0};
      if (wb_en) regs[wb_addr] = wb_data;
      slot = nxt;
   endtask

   // Inputs are already driven at a negedge; check handshake, cross one edge, check the ID/EX beat.
   task automatic step();
      #1;
      check("in_ready", in_ready, model_ready());
      model_advance();
      @(negedge clk);
      check("out_valid", out_valid, slot.v);
      if (slot.v) begin
         check("out_pc", out_pc, slot.pc);
         check("out_instr", out_instr, slot.instr);
         check("out_rn", out_rn, slot.rn);
         check("out_rm", out_rm, slot.rm);
         check("out_dst", out_dst, slot.dst);
         check("out_imm24", out_imm24, slot.instr[23:0]);
         check("out_shift", out_shift, slot.instr[11:0]);
         check("out_ctrl", {out_exe_cmd, out_mem_read, out_mem_write, out_wb_en, out_imm, out_b, out_s},
               {slot.exe, slot.mr, slot.mw, slot.wb, slot.imm, slot.b, slot.s});
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_data"}, {out_pc, out_instr}, 64'd0);
      check({tag, "_ops"}, {out_rn, out_rm}, 64'd0);
      check({tag, "_ctrl"}, {out_valid, out_dst, out_imm24, out_shift, out_exe_cmd, out_mem_read,
                             out_mem_write, out_wb_en, out_imm, out_b, out_s}, 64'd0);
   endtask

   task automatic idle();
      in_valid = 0; wb_en = 0; flush = 0; out_ready = 1; rst = 0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      wb_en = 1; wb_addr = a; wb_data = d;
      step();
      wb_en = 0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [3:0] cond = ($urandom % 10 < 7) ? 4'hE : 4'($urandom);
      logic [1:0] mode = 2'($urandom % 3);
      return mk(cond, mode, 1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom % 8),
                4'($urandom % 8), {8'($urandom), 4'($urandom % 8)});
   endfunction

   initial begin
      idle();
      pc_in = 0; instr_in = 0; wb_addr = 0; wb_data = 0; status = 0;
      rst = 1;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 0;
      check_zero("reset");
      check("reset_in_ready", in_ready, 1'b1);
      step();

      // ADD r1, r2, r3 with r2=5, r3=7
      wr(4'd2, 32'd5);
      wr(4'd3, 32'd7);
      in_valid = 1; pc_in = 32'h100; instr_in = mk(4'hE, 2'b00, 0, 4'h4, 0, 4'd2, 4'd1, 12'h003);
      step();
      in_valid = 0;
      check("add_valid", out_valid, 1'b1);
      check("add_rn", out_rn, 32'd5);
      check("add_rm", out_rm, 32'd7);
      check("add_wb_en", out_wb_en, 1'b1);
      check("add_dst", out_dst, 4'd1);

      // LDR r4,[r5] then dependent ADD r6, r4, r7
      in_valid = 1; pc_in = 32'h104; instr_in = mk(4'hE, 2'b01, 0, 4'h4, 1, 4'd5, 4'd4, 12'h000);
      step();
      pc_in = 32'h108; instr_in = mk(4'hE, 2'b00, 0, 4'h4, 0, 4'd4, 4'd6, 12'h007);
      #1;
      check("lu_in_ready_low", in_ready, 1'b0);
      step();
      check("lu_bubble", out_valid, 1'b0);
      #1;
      check("lu_in_ready_back", in_ready, 1'b1);
      step();
      check("lu_add_valid", out_valid, 1'b1);
      check("lu_add_pc", out_pc, 32'h108);
      in_valid = 0;
      step();

      // ADDEQ with Z clear: beat passes with dead control
      status = 4'b0000;
      in_valid = 1; pc_in = 32'h10C; instr_in = mk(4'h0, 2'b00, 0, 4'h4, 1, 4'd2, 4'd1, 12'h003);
      step();
      in_valid = 0;
      check("condfail_valid", out_valid, 1'b1);
      check("condfail_ctrl", {out_exe_cmd, out_mem_read, out_mem_write, out_wb_en, out_b, out_s}, 64'd0);

      // same-cycle write-back of r2 while reading r2
      in_valid = 1; pc_in = 32'h110; instr_in = mk(4'hE, 2'b00, 0, 4'h4, 0, 4'd2, 4'd1, 12'h003);
      wb_en = 1; wb_addr = 4'd2; wb_data = 32'hDEAD_BEEF;
      step();
      wb_en = 0; in_valid = 0;
      check("bypass_rn", out_rn, 32'hDEAD_BEEF);
      check("nobypass_rn", nb_out_rn, 32'd5);

      // backpressure then flush
      in_valid = 1; pc_in = 32'h200; instr_in = mk(4'hE, 2'b00, 1, 4'hD, 0, 4'd1, 4'd3, 12'h0AB);
      step();
      out_ready = 0; pc_in = 32'h204;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp_in_ready", in_ready, 1'b0);
         step();
         check("bp_pc_hold", out_pc, 32'h200);
      end
      flush = 1;
      step();
      check("flush_valid", out_valid, 1'b0);
      idle();
      step();

      // reset during a load-use stall
      in_valid = 1; pc_in = 32'h300; instr_in = mk(4'hE, 2'b01, 0, 4'h4, 1, 4'd5, 4'd4, 12'h000);
      step();
      pc_in = 32'h304; instr_in = mk(4'hE, 2'b00, 0, 4'h4, 0, 4'd4, 4'd6, 12'h007);
      rst = 1;
      step();
      check_zero("rst_stall");
      idle();
      step();
      check("rst_no_stale", out_valid, 1'b0);
      step();

      for (int cyc = 0; cyc < 800; cyc++) begin
         rst       = ($urandom % 128) == 0;
         flush     = ($urandom % 16) == 0;
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 4) != 0;
         wb_en     = 1'($urandom);
         wb_addr   = 4'($urandom % 8);
         wb_data   = $urandom;
         status    = 4'($urandom);
         pc_in     = 32'(cyc) << 2;
         instr_in  = rand_instr();
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
